wb_mem_tester: RTL and testbench



---
 rtl/wb_mem_tester_pkg.sv | 22 ++
 rtl/wb_if.sv | 20 ++
 rtl/wb_mem_tester.sv | 209 ++++++++++++++++++++
 tb/tb_wb_mem_tester.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_tester_pkg.sv
// rtl/wb_mem_tester_pkg.sv - shared types, widths and pattern function for wb_mem_tester
package wb_mem_tester_pkg;

  localparam int WB_ADR_W = 28;
  localparam int WB_DAT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_DRAIN,
    RD_ISSUE,
    RD_DRAIN,
    DONE
  } state_t;

  // Test pattern for a word address: zero-extended address XOR seed.
  function automatic logic [WB_DAT_W-1:0] pat(input logic [WB_ADR_W-1:0] adr,
                                              input logic [WB_DAT_W-1:0] seed);
    return {4'h0, adr} ^ seed;
  endfunction

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - pipelined Wishbone bus bundle (word address, 32-bit data, stall)
interface wb_if;
  import wb_mem_tester_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_m;
  logic [WB_DAT_W-1:0] dat_s;
  logic [3:0]          sel;
  logic                ack;
  logic                err;
  logic                stall;

  modport master (output cyc, stb, we, adr, dat_m, sel,
                  input  dat_s, ack, err, stall);
  modport slave  (input  cyc, stb, we, adr, dat_m, sel,
                  output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_mem_tester.sv
// rtl/wb_mem_tester.sv - Wishbone write/read-back memory tester; ack watchdog under WB_MEM_TESTER_TIMEOUT_EN
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int LEN_W           = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [WB_ADR_W-1:0] base_adr_i,
  input  logic [LEN_W-1:0]    num_words_i,
  input  logic [WB_DAT_W-1:0] seed_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [LEN_W-1:0]    mismatch_cnt_o,
  output logic [WB_ADR_W-1:0] fail_adr_o,
  output logic                bus_err_o,
  output logic                timeout_o,
  wb_if.master                wbm
);

  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  state_t              state_q, state_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;          // next issue address
  logic [WB_ADR_W-1:0] rsp_adr_q, rsp_adr_d;  // address of the next read response
  logic [WB_ADR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]    num_q, num_d;
  logic [WB_DAT_W-1:0] seed_q, seed_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    rsp_cnt_q, rsp_cnt_d;
  logic [3:0]          outst_q, outst_d;
  logic [LEN_W-1:0]    mism_q, mism_d;
  logic [WB_ADR_W-1:0] fail_adr_q, fail_adr_d;
  logic                bus_err_q, bus_err_d;
  logic                timeout_q, timeout_d;

  logic busy, rd_phase, cyc, stb, accept, ack_v, err_v, last_rd, wd_fire;

  assign busy     = (state_q == WR_ISSUE) || (state_q == WR_DRAIN) ||
                    (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
  assign rd_phase = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
  // cyc falls for the single WR_DRAIN cycle that sees all writes acked.
  assign cyc      = (state_q == WR_ISSUE) || (state_q == RD_ISSUE) || (state_q == RD_DRAIN) ||
                    ((state_q == WR_DRAIN) && (outst_q != 4'd0));
  assign stb      = ((state_q == WR_ISSUE) || (state_q == RD_ISSUE)) &&
                    (issued_q < num_q) && (outst_q < MAX_O);
  assign accept   = stb && !wbm.stall;
  assign err_v    = cyc && wbm.err;
  assign ack_v    = busy && wbm.ack && !wbm.err && (outst_q != 4'd0);
  assign last_rd  = ack_v && rd_phase && (rsp_cnt_q == num_q - LEN_W'(1));

  assign wbm.cyc   = cyc;
  assign wbm.stb   = stb;
  assign wbm.we    = (state_q == WR_ISSUE);
  assign wbm.adr   = adr_q;
  assign wbm.dat_m = (state_q == WR_ISSUE) ? pat(adr_q, seed_q) : '0;
  assign wbm.sel   = 4'hF;

  assign busy_o         = busy;
  assign done_o         = (state_q == DONE);
  assign pass_o         = done_o && !bus_err_q && !timeout_q && (mism_q == '0);
  assign mismatch_cnt_o = mism_q;
  assign fail_adr_o     = fail_adr_q;
  assign bus_err_o      = bus_err_q;
  assign timeout_o      = timeout_q;

`ifdef WB_MEM_TESTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog: count unanswered cycles while requests are outstanding.
  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (!busy || ack_v) begin
      wd_d = '0;
    end else if ((outst_q != 4'd0) && !wbm.err) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) wd_fire = 1'b1;
      else                                   wd_d    = wd_q + WD_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic unused_cfg;
  assign wd_fire    = 1'b0;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state: phase sequencing, issue/response counters, compare and abort.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rsp_adr_d  = rsp_adr_q;
    base_d     = base_q;
    num_d      = num_q;
    seed_d     = seed_q;
    issued_d   = issued_q;
    rsp_cnt_d  = rsp_cnt_q;
    outst_d    = outst_q + {3'b000, accept} - {3'b000, ack_v};
    mism_d     = mism_q;
    fail_adr_d = fail_adr_q;
    bus_err_d  = bus_err_q;
    timeout_d  = timeout_q;

    if (accept) begin
      adr_d    = adr_q + 28'd1;
      issued_d = issued_q + LEN_W'(1);
    end

    if (ack_v && rd_phase) begin
      rsp_adr_d = rsp_adr_q + 28'd1;
      rsp_cnt_d = rsp_cnt_q + LEN_W'(1);
      if (wbm.dat_s != pat(rsp_adr_q, seed_q)) begin
        if (mism_q != '1) mism_d     = mism_q + LEN_W'(1);
        if (mism_q == '0) fail_adr_d = rsp_adr_q;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          base_d     = base_adr_i;
          num_d      = num_words_i;
          seed_d     = seed_i;
          adr_d      = base_adr_i;
          rsp_adr_d  = base_adr_i;
          issued_d   = '0;
          rsp_cnt_d  = '0;
          outst_d    = 4'd0;
          mism_d     = '0;
          fail_adr_d = '0;
          bus_err_d  = 1'b0;
          timeout_d  = 1'b0;
          state_d    = (num_words_i == '0) ? DONE : WR_ISSUE;
        end
      end
      WR_ISSUE: if (issued_q == num_q) state_d = WR_DRAIN;
      WR_DRAIN: begin
        if (outst_q == 4'd0) begin
          state_d   = RD_ISSUE;
          issued_d  = '0;
          adr_d     = base_q;
          rsp_adr_d = base_q;
          rsp_cnt_d = '0;
        end
      end
      RD_ISSUE: begin
        if (last_rd)                 state_d = DONE;
        else if (issued_q == num_q)  state_d = RD_DRAIN;
      end
      RD_DRAIN: if (last_rd) state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (err_v) begin
      bus_err_d = 1'b1;
      state_d   = DONE;
      outst_d   = 4'd0;
    end
    if (wd_fire) begin
      timeout_d = 1'b1;
      state_d   = DONE;
      outst_d   = 4'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      rsp_adr_q  <= '0;
      base_q     <= '0;
      num_q      <= '0;
      seed_q     <= '0;
      issued_q   <= '0;
      rsp_cnt_q  <= '0;
      outst_q    <= 4'd0;
      mism_q     <= '0;
      fail_adr_q <= '0;
      bus_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rsp_adr_q  <= rsp_adr_d;
      base_q     <= base_d;
      num_q      <= num_d;
      seed_q     <= seed_d;
      issued_q   <= issued_d;
      rsp_cnt_q  <= rsp_cnt_d;
      outst_q    <= outst_d;
      mism_q     <= mism_d;
      fail_adr_q <= fail_adr_d;
      bus_err_q  <= bus_err_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_tester.sv
// tb/tb_wb_mem_tester.sv - self-checking bench for wb_mem_tester
module tb_wb_mem_tester;
  import wb_mem_tester_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [27:0] base_adr_i = '0;
  logic [15:0] num_words_i = '0;
  logic [31:0] seed_i = '0;
  logic        busy_o, done_o, pass_o, bus_err_o, timeout_o;
  logic [15:0] mismatch_cnt_o;
  logic [27:0] fail_adr_o;

  wb_if wb();

  wb_mem_tester #(.LEN_W(16), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_adr_i(base_adr_i),
    .num_words_i(num_words_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .mismatch_cnt_o(mismatch_cnt_o), .fail_adr_o(fail_adr_o),
    .bus_err_o(bus_err_o), .timeout_o(timeout_o), .wbm(wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // slave configuration (written by the stimulus only)
  int          stall_en = 0;
  int          no_ack = 0;
  int          err_target = 0;
  int          ncor = 0;
  logic [27:0] cor_a [3];

  // slave / monitor state (written by the always blocks only)
  typedef struct { logic [27:0] adr; logic we; } req_t;
  req_t        rq[$];
  logic [31:0] mem [1024];
  int          outs = 0, max_outs = 0, rd_accepts = 0, wr_ack_total = 0, viol = 0;
  int          cyc_n = 0, last_ack_cyc = 0, done_rise_cyc = 0, gap_cnt = 0;
  logic        done_prev = 1'b0, prev_v = 1'b0, p_we = 1'b0;
  logic [27:0] p_adr = '0;
  logic [31:0] p_dat = '0;

  function automatic bit is_cor(input logic [27:0] a);
    return (ncor > 0 && a == cor_a[0]) || (ncor > 1 && a == cor_a[1]) || (ncor > 2 && a == cor_a[2]);
  endfunction

  // Pipelined slave: accepts when not stalled, answers in order, earliest the next cycle.
  always @(posedge clk) begin
    req_t r;
    int   nv;
    nv = outs;
    if (prev_v && (!wb.stb || wb.adr != p_adr || wb.dat_m != p_dat || wb.we != p_we))
      viol <= viol + 1;
    prev_v <= wb.stb && wb.stall;
    p_adr  <= wb.adr;
    p_dat  <= wb.dat_m;
    p_we   <= wb.we;
    if (!rst_n || !wb.cyc) begin
      rq.delete();
      wb.ack <= 1'b0;
      wb.err <= 1'b0;
      outs   <= 0;
    end else begin
      if (wb.stb && !wb.stall) begin
        r.adr = wb.adr;
        r.we  = wb.we;
        rq.push_back(r);
        nv = nv + 1;
        if (wb.we) mem[wb.adr[9:0]] <= wb.dat_m;
        else       rd_accepts <= rd_accepts + 1;
      end
      if (wb.ack) nv = nv - 1;
      outs <= nv;
      if (nv > max_outs) max_outs <= nv;
      if (no_ack == 0 && rq.size() != 0 && (stall_en == 0 || $urandom_range(0, 3) != 0)) begin
        r = rq.pop_front();
        wb.ack <= 1'b1;
        wb.err <= 1'b0;
        if (r.we) begin
          wb.dat_s     <= '0;
          wr_ack_total <= wr_ack_total + 1;
          if (err_target != 0 && wr_ack_total + 1 == err_target) wb.err <= 1'b1;
        end else begin
          wb.dat_s <= mem[r.adr[9:0]] ^ (is_cor(r.adr) ? 32'h1 : 32'h0);
        end
      end else begin
        wb.ack <= 1'b0;
        wb.err <= 1'b0;
      end
    end
    wb.stall <= (stall_en != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (wb.ack) last_ack_cyc <= cyc_n;
    if (done_o && !done_prev) done_rise_cyc <= cyc_n;
    done_prev <= done_o;
    if (busy_o && !wb.cyc) gap_cnt <= gap_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_o) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":flags"}, {busy_o, done_o, pass_o, bus_err_o, timeout_o, wb.cyc, wb.stb, wb.we}, 8'h00);
    chk({tag, ":mism"}, mismatch_cnt_o, 0);
    chk({tag, ":fail_adr"}, fail_adr_o, 0);
    chk({tag, ":adr_dat"}, {wb.adr, wb.dat_m}, 60'h0);
    chk({tag, ":sel"}, wb.sel, 4'hF);
  endtask

  // Expected result from the rules: reads of corrupted addresses within the range mismatch.
  function automatic void model(input logic [27:0] base, input int num, input int nc,
                                input logic [27:0] c0, input logic [27:0] c1, input logic [27:0] c2,
                                output int mism, output logic [27:0] fa);
    mism = 0;
    fa   = '0;
    for (int i = 0; i < num; i++) begin
      logic [27:0] a;
      a = base + 28'(i);
      if ((nc > 0 && a == c0) || (nc > 1 && a == c1) || (nc > 2 && a == c2)) begin
        if (mism == 0) fa = a;
        mism++;
      end
    end
  endfunction

  task automatic run_vec(input string tag, input logic [27:0] base, input int num,
                         input logic [31:0] seed, input int stall, input int nc,
                         input logic [27:0] c0, input logic [27:0] c1, input logic [27:0] c2,
                         input int exp_pass, input int exp_mism, input logic [27:0] exp_fail);
    int          ok, bad, gap0;
    logic [27:0] a;
    cor_a[0] = c0; cor_a[1] = c1; cor_a[2] = c2;
    ncor = nc;
    stall_en = stall;
    base_adr_i = base; num_words_i = 16'(num); seed_i = seed;
    gap0 = gap_cnt;
    pulse_start();
    @(negedge clk);
    chk({tag, ":first_stb"}, wb.stb, 1);
    wait_done(6000, ok);
    chk({tag, ":done_reached"}, ok, 1);
    @(negedge clk);
    chk({tag, ":pass"}, pass_o, exp_pass);
    chk({tag, ":mism"}, mismatch_cnt_o, exp_mism);
    if (exp_mism != 0) chk({tag, ":fail_adr"}, fail_adr_o, exp_fail);
    chk({tag, ":bus_err"}, bus_err_o, 0);
    chk({tag, ":done_lat"}, done_rise_cyc, last_ack_cyc + 1);
    chk({tag, ":cyc_gap"}, gap_cnt - gap0, 1);
    bad = 0;
    for (int i = 0; i < num; i++) begin
      a = base + 28'(i);
      if (mem[a[9:0]] !== ({4'h0, a} ^ seed)) bad++;
    end
    chk({tag, ":written"}, bad, 0);
    stall_en = 0;
    ncor = 0;
  endtask

  typedef struct {
    logic [27:0] base; int num; logic [31:0] seed; int stall; int nc;
    logic [27:0] c0; logic [27:0] c1; logic [27:0] c2;
    int exp_pass; int exp_mism; logic [27:0] exp_fail;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    int          ok, rd0, t0, em, nc;
    logic [27:0] b, ef, c0, c1, c2;
    logic [31:0] s;
    int          n, st;

    vecs[0] = '{28'h100, 8, 32'hA5A5_0000, 0, 0, 28'h0, 28'h0, 28'h0, 1, 0, 28'h0};
    vecs[1] = '{28'h200, 32, 32'h1234_5678, 1, 0, 28'h0, 28'h0, 28'h0, 1, 0, 28'h0};
    vecs[2] = '{28'h100, 8, 32'hA5A5_0000, 0, 1, 28'h105, 28'h0, 28'h0, 0, 1, 28'h105};
    vecs[3] = '{28'hFFFFFFC, 8, 32'hDEAD_BEEF, 1, 2, 28'h0000001, 28'hFFFFFFE, 28'h0, 0, 2, 28'hFFFFFFE};
    vecs[4] = '{28'h050, 20, 32'h0, 1, 2, 28'h063, 28'h050, 28'h0, 0, 2, 28'h050};

    #2;
    chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].base, vecs[i].num, vecs[i].seed, vecs[i].stall,
              vecs[i].nc, vecs[i].c0, vecs[i].c1, vecs[i].c2,
              vecs[i].exp_pass, vecs[i].exp_mism, vecs[i].exp_fail);

    for (int i = 0; i < 6; i++) begin
      b  = 28'($urandom());
      n  = $urandom_range(1, 40);
      s  = $urandom();
      st = $urandom_range(0, 1);
      nc = $urandom_range(0, 3);
      c0 = b + 28'($urandom_range(0, n - 1));
      c1 = b + 28'($urandom_range(0, n - 1));
      c2 = b + 28'($urandom_range(0, n - 1));
      model(b, n, nc, c0, c1, c2, em, ef);
      run_vec($sformatf("rnd%0d", i), b, n, s, st, nc, c0, c1, c2, (em == 0) ? 1 : 0, em, ef);
    end

    // zero-length test finishes the cycle after start
    base_adr_i = 28'h0; num_words_i = 16'd0; seed_i = 32'h0;
    pulse_start();
    @(negedge clk);
    chk("zero:done", {done_o, pass_o, busy_o, wb.cyc}, 4'b1100);

    // start while busy is ignored
    base_adr_i = 28'h600; num_words_i = 16'd16; seed_i = 32'h0F0F_0F0F;
    rd0 = rd_accepts;
    pulse_start();
    repeat (5) @(negedge clk);
    chk("busy:busy_at_restart", busy_o, 1);
    num_words_i = 16'd0; base_adr_i = 28'h700;
    pulse_start();
    @(negedge clk);
    chk("busy:still_busy", {busy_o, done_o}, 2'b10);
    wait_done(2000, ok);
    chk("busy:done_reached", ok, 1);
    @(negedge clk);
    chk("busy:pass", pass_o, 1);
    chk("busy:reads", rd_accepts - rd0, 16);

    // error on the third write ack
    base_adr_i = 28'h300; num_words_i = 16'd8; seed_i = 32'h5555_AAAA;
    err_target = wr_ack_total + 3;
    rd0 = rd_accepts;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wb.err) begin ok = 1; break; end
    end
    chk("err:seen", ok, 1);
    @(negedge clk);
    chk("err:cyc_stb_dropped", {wb.cyc, wb.stb}, 2'b00);
    chk("err:flags", {done_o, pass_o, bus_err_o, busy_o}, 4'b1010);
    repeat (5) @(negedge clk);
    chk("err:no_reads", rd_accepts - rd0, 0);
    err_target = 0;

    // slave that never acks
    no_ack = 1;
    base_adr_i = 28'h400; num_words_i = 16'd6; seed_i = 32'h1;
    pulse_start();
    t0 = cyc_n;
`ifdef WB_MEM_TESTER_TIMEOUT_EN
    wait_done(400, ok);
    chk("tmo:done_reached", ok, 1);
    chk("tmo:elapsed_ge_256", (cyc_n - t0) >= 256, 1);
    chk("tmo:flags", {timeout_o, pass_o, bus_err_o}, 3'b100);
`else
    repeat (300) @(negedge clk);
    chk("noack:still_busy", {busy_o, done_o, timeout_o}, 3'b100);
`endif
    pulse_start();
    repeat (10) @(negedge clk);
    chk("noack:busy", busy_o, 1);
    chk("max_outstanding", max_outs, 4);
    chk("stall_stable", viol, 0);

    // asynchronous reset in the middle of a run
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid");
    no_ack = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
